// File: rtl/dataslot_arbiter_pkg.sv
// Shared pocket package for the dataslot arbiter.
// Holds the per-requester command record, the arbiter state encoding and
// the default watchdog limit (about 100 ms of clk_74a).
package dataslot_arbiter_pkg;

  typedef struct packed {
    logic        write;
    logic [15:0] id;
    logic [31:0] slotoffset;
    logic [31:0] bridgeaddr;
    logic [31:0] length;
  } dataslot_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dataslot_arb_state_t;

  localparam int DATASLOT_ARB_TIMEOUT_DEFAULT = 7_425_000;

endpackage

// File: rtl/dataslot_arbiter_rr_arbiter.sv
// Round-robin requester select for the dataslot arbiter (combinational).
// Ports:
//   req       - per-requester request level
//   last_idx  - index of the most recently granted requester
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - binary index of the granted requester
// The search begins at last_idx+1 and wraps, so the last winner has the
// lowest priority on the next pass.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  always_comb begin
    int          j;
    logic        found;
    logic [IW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last_idx) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dataslot_arbiter.sv
// Dataslot arbiter: shares one APF bridge dataslot target port among
// NUM_REQ requesters.
//
// state | meaning
// IDLE  | no command; arbitrate any pending req
// ISSUE | command latched, read/write strobe high until ack seen
// WAIT  | strobes low, waiting for bridge ack to fall
// DONE  | one-cycle done pulse to the granted requester
//
// Ports:
//   clk_74a, reset                - clock, synchronous active-high reset
//   req, cmd                      - per-requester request level and command
//   done, error                   - per-requester completion / timeout pulse
//   busy, processor_halt          - status (not IDLE / in ISSUE or WAIT)
//   target_dataslot_read/write    - bridge strobes
//   target_dataslot_ack           - bridge acknowledge
//   target_dataslot_id/slotoffset/bridgeaddr/length - latched command fields
//
// Build option: define DATASLOT_ARB_TIMEOUT_EN to add a watchdog that
// aborts a command after TIMEOUT_CYCLES cycles in ISSUE/WAIT with an error
// pulse. Without it, error is tied low and the arbiter waits forever.
module dataslot_arbiter
  import dataslot_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DATASLOT_ARB_TIMEOUT_DEFAULT
) (
  input  logic                              clk_74a,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  dataslot_cmd_t [NUM_REQ-1:0]       cmd,
  output logic [NUM_REQ-1:0]                done,
  output logic [NUM_REQ-1:0]                error,
  output logic                              busy,
  output logic                              processor_halt,
  output logic                              target_dataslot_read,
  output logic                              target_dataslot_write,
  input  logic                              target_dataslot_ack,
  output logic [15:0]                       target_dataslot_id,
  output logic [31:0]                       target_dataslot_slotoffset,
  output logic [31:0]                       target_dataslot_bridgeaddr,
  output logic [31:0]                       target_dataslot_length
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("dataslot_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  dataslot_arb_state_t state_q, state_d;
  dataslot_cmd_t       cmd_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IW-1:0]       last_idx_q;
  logic                ack_q;
  logic [NUM_REQ-1:0]  rr_grant;
  logic [IW-1:0]       rr_idx;
  logic                start;
  logic                in_cmd;
  logic                timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .last_idx  (last_idx_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign start  = (state_q == ST_IDLE) && (|req);
  assign in_cmd = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Timeout has priority over ack so an abort never also produces done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (timeout)    state_d = ST_IDLE;
        else if (ack_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timeout)     state_d = ST_IDLE;
        else if (!ack_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The bridge ack is registered once before the FSM looks at it; this
  // gives the two-cycle ack-fall-to-done latency.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      cmd_q      <= '0;
      grant_q    <= '0;
      last_idx_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      ack_q   <= target_dataslot_ack;
      if (start) begin
        cmd_q      <= cmd[rr_idx];
        grant_q    <= rr_grant;
        last_idx_q <= rr_idx;
      end
    end
  end

`ifdef DATASLOT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_cnt_q;

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (start) begin
      wd_cnt_q <= '0;
    end else if (in_cmd) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign timeout = in_cmd && (wd_cnt_q == TIMEOUT_LAST);
  assign error   = timeout ? grant_q : '0;
`else
  assign timeout = 1'b0;
  assign error   = '0;
`endif

  assign busy                  = (state_q != ST_IDLE);
  assign processor_halt        = in_cmd;
  assign target_dataslot_read  = (state_q == ST_ISSUE) && !cmd_q.write;
  assign target_dataslot_write = (state_q == ST_ISSUE) &&  cmd_q.write;
  assign done                  = (state_q == ST_DONE) ? grant_q : '0;

  assign target_dataslot_id         = cmd_q.id;
  assign target_dataslot_slotoffset = cmd_q.slotoffset;
  assign target_dataslot_bridgeaddr = cmd_q.bridgeaddr;
  assign target_dataslot_length     = cmd_q.length;

endmodule

// File: tb/tb_dataslot_arbiter.sv
// Self-checking bench for dataslot_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=100).
// Expected done/error pulses are queued when a command is launched and
// popped by a monitor when the DUT pulses.
module tb_dataslot_arbiter;
  import dataslot_arbiter_pkg::*;

  logic                 clk_74a = 1'b0;
  logic                 reset;
  logic [1:0]           req;
  dataslot_cmd_t [1:0]  cmd;
  logic [1:0]           done;
  logic [1:0]           error;
  logic                 busy;
  logic                 halt;
  logic                 rd;
  logic                 wr;
  logic                 ack;
  logic [15:0]          t_id;
  logic [31:0]          t_slot;
  logic [31:0]          t_baddr;
  logic [31:0]          t_len;

  dataslot_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(100)) dut (
    .clk_74a                    (clk_74a),
    .reset                      (reset),
    .req                        (req),
    .cmd                        (cmd),
    .done                       (done),
    .error                      (error),
    .busy                       (busy),
    .processor_halt             (halt),
    .target_dataslot_read       (rd),
    .target_dataslot_write      (wr),
    .target_dataslot_ack        (ack),
    .target_dataslot_id         (t_id),
    .target_dataslot_slotoffset (t_slot),
    .target_dataslot_bridgeaddr (t_baddr),
    .target_dataslot_length     (t_len)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct packed {
    logic       is_err;
    logic [2:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [1:0] prev_done = '0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic push_exp(input logic is_err, input int idx);
    exp_t e;
    e.is_err = is_err;
    e.idx    = 3'(idx);
    sb_q.push_back(e);
  endtask

  task automatic wait_strobe(output int n, input int budget);
    n = 0;
    while (!(rd || wr) && n < budget) begin
      tick();
      n++;
    end
    check_value("strobe_seen", rd || wr, 1);
  endtask

  task automatic wait_done(output int n, input int budget);
    n = 0;
    while (!(|done) && n < budget) begin
      tick();
      n++;
    end
    check_value("done_seen", |done, 1);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard monitor plus per-cycle protocol checks.
  always @(negedge clk_74a) begin
    exp_t       e;
    logic [1:0] oh;
    if (!reset) begin
      check_value("rw_excl", rd & wr, 0);
      if (|done || |error) begin
        if (sb_q.size() == 0) begin
          check_value("unexp_pulse", {error, done}, 0);
        end else begin
          e  = sb_q.pop_front();
          oh = 2'b01 << e.idx;
          check_value("pulse_kind", |error, e.is_err);
          check_value("pulse_req", (|error) ? error : done, oh);
        end
        check_value("done_1cyc", done & prev_done, 0);
      end
      prev_done = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic gi;
    reset = 1'b1;
    req   = '0;
    ack   = 1'b0;
    cmd   = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_value("rst_status", {busy, halt, rd, wr, done, error}, 0);
    check_value("rst_fields", {t_id, t_slot, t_baddr, t_len}, 0);

    // Single read
    cmd[0] = '{write: 1'b0, id: 16'h0002, slotoffset: 32'h40,
               bridgeaddr: 32'h1000_0000, length: 32'h100};
    push_exp(1'b0, 0);
    req = 2'b01;
    tick();
    check_value("sr_strobe_lat", {wr, rd}, 2'b01);
    check_value("sr_halt_busy", {halt, busy}, 2'b11);
    check_value("sr_id", t_id, 16'h0002);
    check_value("sr_len", t_len, 32'h100);
    check_value("sr_baddr", t_baddr, 32'h1000_0000);
    check_value("sr_slot", t_slot, 32'h40);
    tick(); tick(); tick();
    check_value("sr_read_pre_ack", rd, 1);
    ack = 1'b1;
    tick();
    check_value("sr_read_ack_reg", {halt, rd}, 2'b11);
    tick();
    check_value("sr_wait", {halt, rd, wr}, 3'b100);
    for (int i = 0; i < 48; i++) begin
      tick();
      check_value("sr_wait_hold", {busy, halt, rd, wr, done}, 6'b110000);
    end
    ack = 1'b0;
    tick();
    check_value("sr_done_early", {done, halt}, 3'b001);
    tick();
    check_value("sr_done_2cyc", done, 2'b01);
    req = 2'b00;
    tick();
    check_value("sr_idle", {busy, done}, 0);

    // Contention, fresh pointer
    reset_pulse();
    cmd[0] = '{write: 1'b1, id: 16'h0010, slotoffset: 32'h0,
               bridgeaddr: 32'h2000_0000, length: 32'h20};
    cmd[1] = '{write: 1'b0, id: 16'h0011, slotoffset: 32'h8,
               bridgeaddr: 32'h3000_0000, length: 32'h40};
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      gi = 1'(k % 2);
      push_exp(1'b0, k % 2);
      wait_strobe(n, 10);
      check_value("c_gap", n, (k == 0) ? 1 : 2);
      check_value("c_id", t_id, cmd[gi].id);
      check_value("c_strobe", {wr, rd}, gi ? 2'b01 : 2'b10);
      ack = 1'b1;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (!gi) check_value("c_wr_only", rd, 0);
      end
      ack = 1'b0;
      wait_done(n, 10);
      check_value("c_ackfall_done", n, 2);
      check_value("c_done_idx", done, gi ? 2'b10 : 2'b01);
      if (k == 3) req = 2'b00;
    end
    tick();

    // Early release by the granted requester; other requester arrives mid-command
    cmd[0] = '{write: 1'b0, id: 16'h0020, slotoffset: 32'h0,
               bridgeaddr: 32'h4000_0000, length: 32'h0};
    cmd[1] = '{write: 1'b1, id: 16'h0021, slotoffset: 32'h0,
               bridgeaddr: 32'h5000_0000, length: 32'h10};
    push_exp(1'b0, 0);
    req = 2'b01;
    wait_strobe(n, 10);
    ack = 1'b1;
    tick(); tick();
    check_value("er_wait", {halt, rd, wr}, 3'b100);
    req = 2'b10;
    push_exp(1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("er_unaffected", {busy, t_id}, {1'b1, 16'h0020});
    end
    ack = 1'b0;
    wait_done(n, 10);
    check_value("er_done0", done, 2'b01);
    wait_strobe(n, 10);
    check_value("er_next_gap", n, 2);
    check_value("er_next_id", t_id, 16'h0021);
    check_value("er_next_wr", {wr, rd}, 2'b10);
    ack = 1'b1;
    tick(); tick(); tick();
    ack = 1'b0;
    wait_done(n, 10);
    check_value("er_done1", done, 2'b10);
    req = 2'b00;
    tick();

    // Reset during WAIT
    cmd[0] = '{write: 1'b0, id: 16'h0030, slotoffset: 32'h0,
               bridgeaddr: 32'h6000_0000, length: 32'h4};
    cmd[1] = '{write: 1'b1, id: 16'h0031, slotoffset: 32'h0,
               bridgeaddr: 32'h7000_0000, length: 32'h4};
    req = 2'b11;
    wait_strobe(n, 10);
    check_value("rw_pre_id", t_id, 16'h0030);
    ack = 1'b1;
    tick(); tick(); tick();
    check_value("rw_in_wait", {halt, rd, wr}, 3'b100);
    reset = 1'b1;
    ack   = 1'b0;
    tick();
    check_value("rw_after_rst", {busy, halt, rd, wr, done, error}, 0);
    check_value("rw_fields_clr", t_id, 0);
    reset = 1'b0;
    push_exp(1'b0, 0);
    wait_strobe(n, 10);
    check_value("rw_restart_lat", n, 1);
    check_value("rw_restart_id", t_id, 16'h0030);
    check_value("rw_restart_rd", {wr, rd}, 2'b01);
    ack = 1'b1;
    tick(); tick(); tick(); tick();
    ack = 1'b0;
    wait_done(n, 10);
    check_value("rw_done0", done, 2'b01);
    req = 2'b00;
    tick();

    // Watchdog: ack never arrives; zero length passes through unchanged
    cmd[0] = '{write: 1'b0, id: 16'h0040, slotoffset: 32'h0,
               bridgeaddr: 32'h8000_0000, length: 32'h0};
    req = 2'b01;
    tick();
    n = 1;
    check_value("to_len0", {t_id, t_len}, {16'h0040, 32'h0});
    check_value("to_issue", {busy, halt, rd}, 3'b111);
`ifdef DATASLOT_ARB_TIMEOUT_EN
    push_exp(1'b1, 0);
    while (!(|error) && n < 300) begin
      tick();
      n++;
    end
    check_value("to_seen", |error, 1);
    check_value("to_cycle", n, 100);
    check_value("to_err_idx", {error, done}, 4'b0100);
    req = 2'b00;
    tick();
    check_value("to_idle", {busy, halt, rd, wr, error}, 0);
`else
    for (int i = 0; i < 149; i++) tick();
    check_value("to_stuck", {busy, halt, rd, wr}, 4'b1110);
    check_value("to_no_err", {error, done}, 0);
    req = 2'b00;
    reset_pulse();
    tick();
    check_value("to_recover", busy, 0);
`endif

    tick();
    check_value("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dataslot_arbiter.md
DATASLOT_ARBITER -- requirements
Module: dataslot_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 2: number of requesters, legal range 2..8.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 7_425_000: watchdog limit in clk_74a cycles, about 100 ms.
REQ-003 Port clk_74a, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, NUM_REQ: per-requester level request; it is held until that requester's done or error pulse.
REQ-006 Port cmd, input, NUM_REQ x dataslot_cmd_t: per-requester command; it is stable while req is high.
REQ-007 Port done, output, NUM_REQ: one-cycle pulse on successful completion.
REQ-008 Port error, output, NUM_REQ: one-cycle pulse on timeout.
REQ-009 Port busy, output, 1: high in every state other than IDLE.
REQ-010 Port processor_halt, output, 1: high in ISSUE and WAIT.
REQ-011 Port target_dataslot_read, output, 1: bridge read strobe, rising-edge triggered.
REQ-012 Port target_dataslot_write, output, 1: bridge write strobe, rising-edge triggered.
REQ-013 Port target_dataslot_ack, input, 1: driven by the bridge; high from command start until completion.
REQ-014 Ports target_dataslot_id (output, 16), target_dataslot_slotoffset (output, 32), target_dataslot_bridgeaddr (output, 32) and target_dataslot_length (output, 32) SHALL carry the latched command fields.

Function
REQ-015 The state machine SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE with any req bit high, the arbiter SHALL select one requester by round-robin and move to ISSUE on the next edge.
- The round-robin search starts at the index after the last granted requester.
- After reset, the search starts at index 0.
REQ-017 On the IDLE-to-ISSUE edge, the arbiter SHALL latch the selected cmd into the target_dataslot_* outputs and hold it until the next grant.
REQ-018 In ISSUE, the arbiter SHALL drive target_dataslot_write = cmd.write and target_dataslot_read = !cmd.write.
- Read and write SHALL never be high together.
REQ-019 When target_dataslot_ack is sampled high in ISSUE, the arbiter SHALL drop both strobes and move to WAIT.
REQ-020 When target_dataslot_ack is sampled low in WAIT, the arbiter SHALL move to DONE.
REQ-021 In DONE, the arbiter SHALL pulse done[granted] for exactly one cycle, then return to IDLE.
- done[granted] is therefore never high on two consecutive cycles.
REQ-022 The minimum req-to-strobe latency SHALL be 1 cycle.
- The minimum ack-fall-to-done latency SHALL be 2 cycles.
REQ-023 If the granted requester drops req mid-command, the arbiter SHALL ignore it and the command SHALL complete.
- The requester still receives its done or error pulse.
REQ-024 If a non-granted requester changes its req while the arbiter is busy, the arbiter SHALL not be affected.
- That request is arbitrated only on return to IDLE.
REQ-025 After DONE, the arbiter SHALL spend at least one cycle in IDLE, so the strobes are low for at least two cycles between commands.
REQ-026 A cmd.length of 0 SHALL be issued unchanged; the arbiter does no range checking.

Reset
REQ-027 While reset is high, the arbiter SHALL go to IDLE.
- Reset clears all strobes, done, error, busy and processor_halt to 0.
- Reset sets the target_dataslot_* fields to 0 and the round-robin pointer to NUM_REQ-1.
- The watchdog counter is cleared.
REQ-028 A reset during ISSUE or WAIT SHALL abandon the command with no done or error pulse.
- The strobes SHALL be low on the first cycle after reset is sampled.

Configuration
REQ-029 Macro DATASLOT_ARB_TIMEOUT_EN SHALL control the watchdog.
REQ-030 With DATASLOT_ARB_TIMEOUT_EN defined:
- A counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT.
- When the counter reaches TIMEOUT_CYCLES-1, the arbiter SHALL pulse error[granted] for one cycle, drop the strobes and go to IDLE with no done pulse.
REQ-031 Without DATASLOT_ARB_TIMEOUT_EN:
- No counter SHALL be synthesised.
- error SHALL be tied to 0.
- The arbiter waits on ack indefinitely.

Structure
REQ-032 Typedef dataslot_cmd_t SHALL be defined in the shared pocket package as a packed struct:
- write, 1 bit.
- id, 16 bits.
- slotoffset, 32 bits.
- bridgeaddr, 32 bits.
- length, 32 bits.
REQ-033 The state enum and the default TIMEOUT_CYCLES constant SHALL also be defined in the pocket package.
REQ-034 Requester selection SHALL be a sub-module, rr_arbiter, parameterised by NUM_REQ.
- Inputs: req and a last-grant pointer.
- Outputs: a one-hot grant plus its index.
- It is purely combinational.

Verification
REQ-035 Single read: the bench SHALL check the following.
- Stimulus: req[0] with write=0, id=16'h0002, length=32'h100; ack rises 3 cycles after the strobe and falls 50 cycles later.
- Required: read high from cycle 1 until ack is sampled high; done[0] pulses 2 cycles after ack falls; processor_halt is high throughout ISSUE and WAIT.
REQ-036 Contention: the bench SHALL check the following.
- Stimulus: req=2'b11 held, both requesters re-requesting after each done.
- Required: grants alternate 0,1,0,1; a write command produces a write strobe only, with read never high.
REQ-037 Early release: the bench SHALL check the following.
- Stimulus: the granted requester drops req during WAIT.
- Required: the command completes and done still pulses.
REQ-038 Reset during WAIT: the bench SHALL check the following.
- Stimulus: reset asserted for 1 cycle while in WAIT.
- Required: busy=0, strobes=0 and no done pulse on the next cycle; the pointer restarts so requester 0 wins with req=2'b11.
REQ-039 Timeout, with DATASLOT_ARB_TIMEOUT_EN defined: the bench SHALL check the following.
- Stimulus: TIMEOUT_CYCLES=100 and ack never asserted.
- Required: error[0] pulses 100 cycles after entry to ISSUE; no done pulse; return to IDLE.
- Without the macro, under the same stimulus, the arbiter stays in ISSUE.
